decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter I_WIDTH, default 12: instruction width.
REQ-002 SHALL have parameter A_WIDTH, default 8: instruction address width.
REQ-003 SHALL have parameter HOLD_CYCLES, default 2, range 1-7: cycles of instruction_ready_i ignored after a restart pulse.
REQ-004 Ports SHALL be:
- clk  in  1  single clock; all state updates on its rising edge.
- reset_i  in  1  synchronous, active-high reset.
- instruction_data_i  in  I_WIDTH  instruction at the fetch FIFO head.
- instruction_addr_i  in  A_WIDTH  address of that instruction.
- instruction_ready_i  in  1  fetch FIFO head valid.
- deque_o  out  1  pops the fetch FIFO head this cycle.
- restart_o  out  1  one-cycle restart request to fetch.
- restart_addr_o  out  A_WIDTH  restart target, valid while restart_o=1.
- stall_i  in  1  execute cannot accept the issued instruction.
- redirect_i  in  1  execute resolved a taken control transfer.
- redirect_addr_i  in  A_WIDTH  target for redirect_i.
- valid_o  out  1  issue register holds a live instruction.
- opcode_o  out  3  bits [11:9].
- ra_o  out  3  bits [8:6].
- rb_o  out  3  bits [5:3].
- imm_o  out  A_WIDTH  bits [5:0] sign-extended to A_WIDTH.
- pc_o  out  A_WIDTH  address of the issued instruction.

Function
REQ-005 States SHALL be RUN, RESTART and HOLD.
REQ-006 deque_o SHALL be combinational: instruction_ready_i AND state==RUN AND NOT redirect_i AND (NOT valid_o OR NOT stall_i).
REQ-007 When deque_o=1, the issue register SHALL capture instruction_data_i and instruction_addr_i, and valid_o SHALL be 1 on the next cycle.
REQ-008 When valid_o=1 AND stall_i=1 AND NOT redirect_i, the issue register and all decoded outputs SHALL hold unchanged.
REQ-009 When valid_o=1 AND stall_i=0 AND deque_o=0, valid_o SHALL clear next cycle, producing a bubble.
REQ-010 Issue latency SHALL be 1 cycle, FIFO head to valid_o; throughput SHALL be 1 instruction per cycle with no stall.
REQ-011 Decoded outputs SHALL be combinational functions of the issue register; imm_o SHALL replicate bit 5 into bits A_WIDTH-1:6.
REQ-012 On redirect_i=1 in any state:
- valid_o SHALL clear next cycle.
- redirect_addr_i SHALL be captured.
- state SHALL go to RESTART.
- redirect_i SHALL take priority over stall_i and deque.
REQ-013 In RESTART, restart_o SHALL be 1 with restart_addr_o equal to the captured address. The next state SHALL be HOLD with the hold counter loaded to HOLD_CYCLES.
REQ-014 In HOLD, the counter SHALL decrement each cycle. At count 1 the state SHALL return to RUN, and deque_o SHALL remain 0 throughout HOLD.
REQ-015 redirect_i during RESTART or HOLD SHALL recapture the address and re-enter RESTART; the latest redirect wins.
REQ-016 restart_o SHALL be 0 outside RESTART.
REQ-017 The hold counter SHALL be 3 bits and SHALL never wrap below 1.

Reset
REQ-018 reset_i SHALL override all other inputs.
REQ-019 The cycle after reset_i SHALL have:
- state=RESTART, captured address 0, so boot fetches from address 0.
- valid_o=0, deque_o=0, issue register 0, so all decoded outputs are 0.
REQ-020 reset_i asserted mid-HOLD or mid-stall SHALL discard the held instruction and the counter value.

Configuration
REQ-021 With DECODE_STATS_EN defined, the block SHALL add these outputs:
- issued_cnt_o (16 bits): counts cycles with deque_o=1.
- bubble_cnt_o (16 bits): counts cycles with valid_o=0 outside reset.
- Both SHALL saturate at 16'hFFFF and reset to 0.
REQ-022 Without DECODE_STATS_EN, those ports and counters SHALL not exist and behaviour SHALL be otherwise identical.

Structure
REQ-023 Package decode_pkg SHALL hold the state enum type, the opcode typedef (3 bits) and the field bit-position constants.
REQ-024 Field extraction and sign extension SHALL live in one combinational sub-module, decode_fields. The FSM, issue register and counters SHALL live in decode_stage.

Verification
REQ-025 Reset boot: pulse reset_i, with instruction_ready_i=1 -> next cycle restart_o=1 with restart_addr_o=0. deque_o=0 for the following 2 cycles, then 1.
REQ-026 Streaming: addresses 0x10-0x13 ready, stall_i=0 -> valid_o continuous for 4 cycles, pc_o=0x10..0x13, one cycle after each deque.
REQ-027 Decode: 12'hE3F issued -> opcode_o=3'b111, ra_o=3'b000, rb_o=3'b111, imm_o=8'hFF. 12'h21A issued -> imm_o=8'h1A.
REQ-028 Stall: stall_i=1 for 3 cycles with valid_o=1 and FIFO ready -> deque_o=0, outputs stable. Release -> next instruction issues the following cycle.
REQ-029 Redirect during stall: redirect_i=1 with addr 0x40 while stalled:
- next cycle valid_o=0, restart_o=1, restart_addr_o=0x40.
- a second redirect with addr 0x55 during HOLD -> restart_o re-pulses with 0x55.
REQ-030 Stats (DECODE_STATS_EN): 70000 streaming cycles -> issued_cnt_o=16'hFFFF, no wrap.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared types and instruction field positions for the decode stage.
package decode_pkg;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StRestart = 2'd1,
        StHold    = 2'd2
    } state_e;

    typedef logic [2:0] opcode_t;

    localparam int unsigned FieldWidth = 3;
    localparam int unsigned OpcodeLsb  = 9;
    localparam int unsigned RaLsb      = 6;
    localparam int unsigned RbLsb      = 3;
    localparam int unsigned ImmWidth   = 6;
    localparam int unsigned ImmSignBit = 5;

endpackage

// File: rtl/decode_fields.sv
// Combinational field extraction and immediate sign extension from the issue register.
module decode_fields
    import decode_pkg::*;
#(
    parameter int unsigned I_WIDTH = 12,
    parameter int unsigned A_WIDTH = 8
) (
    input  logic [I_WIDTH-1:0] i_instr,
    output opcode_t            o_opcode,
    output logic [2:0]         o_ra,
    output logic [2:0]         o_rb,
    output logic [A_WIDTH-1:0] o_imm
);

    assign o_opcode = i_instr[OpcodeLsb +: FieldWidth];
    assign o_ra     = i_instr[RaLsb +: FieldWidth];
    assign o_rb     = i_instr[RbLsb +: FieldWidth];
    assign o_imm    = {{(A_WIDTH - ImmWidth){i_instr[ImmSignBit]}}, i_instr[ImmWidth-1:0]};

endmodule

// File: rtl/decode_stage.sv
// Decode/issue stage: FSM with restart/hold after redirect, one-entry issue register.
// Optional DECODE_STATS_EN adds saturating issued/bubble counters.
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned I_WIDTH     = 12,
    parameter int unsigned A_WIDTH     = 8,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset_i,
    input  logic [I_WIDTH-1:0] instruction_data_i,
    input  logic [A_WIDTH-1:0] instruction_addr_i,
    input  logic               instruction_ready_i,
    output logic               deque_o,
    output logic               restart_o,
    output logic [A_WIDTH-1:0] restart_addr_o,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [A_WIDTH-1:0] redirect_addr_i,
    output logic               valid_o,
    output logic [2:0]         opcode_o,
    output logic [2:0]         ra_o,
    output logic [2:0]         rb_o,
    output logic [A_WIDTH-1:0] imm_o,
    output logic [A_WIDTH-1:0] pc_o
`ifdef DECODE_STATS_EN
    ,
    output logic [15:0]        issued_cnt_o,
    output logic [15:0]        bubble_cnt_o
`endif
);

    localparam logic [2:0] HoldInit = 3'(HOLD_CYCLES);

    state_e             r_state, w_state_next;
    logic [2:0]         r_hold_cnt, w_hold_cnt_next;
    logic [A_WIDTH-1:0] r_restart_addr, w_restart_addr_next;
    logic               r_valid, w_valid_next;
    logic [I_WIDTH-1:0] r_instr, w_instr_next;
    logic [A_WIDTH-1:0] r_pc, w_pc_next;
    logic               w_deque;
    opcode_t            w_opcode;

    assign w_deque = instruction_ready_i && (r_state == StRun) && !redirect_i &&
                     (!r_valid || !stall_i);

    always_comb begin
        w_state_next        = r_state;
        w_hold_cnt_next     = r_hold_cnt;
        w_restart_addr_next = r_restart_addr;
        w_valid_next        = r_valid;
        w_instr_next        = r_instr;
        w_pc_next           = r_pc;
        if (redirect_i) begin
            // Redirect beats stall and deque; latest target wins.
            w_state_next        = StRestart;
            w_restart_addr_next = redirect_addr_i;
            w_valid_next        = 1'b0;
        end else begin
            case (r_state)
                StRestart: begin
                    w_state_next    = StHold;
                    w_hold_cnt_next = HoldInit;
                end
                StHold: begin
                    if (r_hold_cnt <= 3'd1) begin
                        w_state_next = StRun;
                    end else begin
                        w_hold_cnt_next = r_hold_cnt - 3'd1;
                    end
                end
                default: ;
            endcase
            if (w_deque) begin
                w_valid_next = 1'b1;
                w_instr_next = instruction_data_i;
                w_pc_next    = instruction_addr_i;
            end else if (r_valid && !stall_i) begin
                w_valid_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_state        <= StRestart;
            r_hold_cnt     <= 3'd0;
            r_restart_addr <= '0;
            r_valid        <= 1'b0;
            r_instr        <= '0;
            r_pc           <= '0;
        end else begin
            r_state        <= w_state_next;
            r_hold_cnt     <= w_hold_cnt_next;
            r_restart_addr <= w_restart_addr_next;
            r_valid        <= w_valid_next;
            r_instr        <= w_instr_next;
            r_pc           <= w_pc_next;
        end
    end

    decode_fields #(
        .I_WIDTH (I_WIDTH),
        .A_WIDTH (A_WIDTH)
    ) u_fields (
        .i_instr  (r_instr),
        .o_opcode (w_opcode),
        .o_ra     (ra_o),
        .o_rb     (rb_o),
        .o_imm    (imm_o)
    );

    assign deque_o        = w_deque;
    assign restart_o      = (r_state == StRestart);
    assign restart_addr_o = r_restart_addr;
    assign valid_o        = r_valid;
    assign opcode_o       = w_opcode;
    assign pc_o           = r_pc;

`ifdef DECODE_STATS_EN
    logic [15:0] r_issued_cnt, r_bubble_cnt;

    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_issued_cnt <= 16'd0;
            r_bubble_cnt <= 16'd0;
        end else begin
            if (w_deque && (r_issued_cnt != 16'hFFFF)) begin
                r_issued_cnt <= r_issued_cnt + 16'd1;
            end
            if (!r_valid && (r_bubble_cnt != 16'hFFFF)) begin
                r_bubble_cnt <= r_bubble_cnt + 16'd1;
            end
        end
    end

    assign issued_cnt_o = r_issued_cnt;
    assign bubble_cnt_o = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized traffic
// against a cycle-count reference model. Define DECODE_STATS_EN to cover the counters.
module tb_decode_stage;

    localparam int unsigned IW   = 12;
    localparam int unsigned AW   = 8;
    localparam int unsigned HOLD = 2;

    logic          clk = 1'b0;
    logic          reset_i;
    logic [IW-1:0] instruction_data_i;
    logic [AW-1:0] instruction_addr_i;
    logic          instruction_ready_i;
    logic          deque_o;
    logic          restart_o;
    logic [AW-1:0] restart_addr_o;
    logic          stall_i;
    logic          redirect_i;
    logic [AW-1:0] redirect_addr_i;
    logic          valid_o;
    logic [2:0]    opcode_o;
    logic [2:0]    ra_o;
    logic [2:0]    rb_o;
    logic [AW-1:0] imm_o;
    logic [AW-1:0] pc_o;
`ifdef DECODE_STATS_EN
    logic [15:0]   issued_cnt_o;
    logic [15:0]   bubble_cnt_o;
`endif

    always #5 clk = ~clk;

    decode_stage #(
        .I_WIDTH     (IW),
        .A_WIDTH     (AW),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk                 (clk),
        .reset_i             (reset_i),
        .instruction_data_i  (instruction_data_i),
        .instruction_addr_i  (instruction_addr_i),
        .instruction_ready_i (instruction_ready_i),
        .deque_o             (deque_o),
        .restart_o           (restart_o),
        .restart_addr_o      (restart_addr_o),
        .stall_i             (stall_i),
        .redirect_i          (redirect_i),
        .redirect_addr_i     (redirect_addr_i),
        .valid_o             (valid_o),
        .opcode_o            (opcode_o),
        .ra_o                (ra_o),
        .rb_o                (rb_o),
        .imm_o               (imm_o),
        .pc_o                (pc_o)
`ifdef DECODE_STATS_EN
        ,
        .issued_cnt_o        (issued_cnt_o),
        .bubble_cnt_o        (bubble_cnt_o)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: m_wait counts remaining non-run cycles (restart pulse + hold cycles).
    int          m_wait;
    logic        m_valid;
    logic [11:0] m_instr;
    logic [7:0]  m_pc;
    logic [7:0]  m_raddr;
    int          m_issued;
    int          m_bubble;
    logic [7:0]  fetch_pc;
    logic [11:0] mem [256];

    logic        s_deque, s_restart, s_valid;
    logic [7:0]  s_raddr, s_pc, s_imm;
    logic [2:0]  s_opcode, s_ra, s_rb;

    function automatic logic [7:0] sext6(input logic [11:0] ins);
        int v;
        v = int'(ins) % 64;
        if (v >= 32) v = v - 64;
        return 8'(v);
    endfunction

    task automatic cycle(input logic rst, input logic rdy, input logic stl, input logic rdr,
                         input logic [7:0] rda, input bit chk);
        logic e_deque, e_restart;
        reset_i             = rst;
        instruction_ready_i = rdy;
        instruction_addr_i  = fetch_pc;
        instruction_data_i  = mem[fetch_pc];
        stall_i             = stl;
        redirect_i          = rdr;
        redirect_addr_i     = rda;
        @(negedge clk);
        e_restart = (m_wait == HOLD + 1);
        e_deque   = rdy && (m_wait == 0) && !rdr && (!m_valid || !stl);
        s_deque = deque_o; s_restart = restart_o; s_raddr = restart_addr_o;
        s_valid = valid_o; s_pc = pc_o; s_opcode = opcode_o; s_ra = ra_o; s_rb = rb_o;
        s_imm = imm_o;
        if (chk) begin
            check_eq("deque", deque_o, e_deque);
            check_eq("restart", restart_o, e_restart);
            if (e_restart) check_eq("restart_addr", restart_addr_o, m_raddr);
            check_eq("valid", valid_o, m_valid);
            check_eq("pc", pc_o, m_pc);
            check_eq("opcode", opcode_o, 32'((m_instr >> 9) % 8));
            check_eq("ra", ra_o, 32'((m_instr >> 6) % 8));
            check_eq("rb", rb_o, 32'((m_instr >> 3) % 8));
            check_eq("imm", imm_o, sext6(m_instr));
`ifdef DECODE_STATS_EN
            check_eq("issued_cnt", issued_cnt_o, m_issued);
            check_eq("bubble_cnt", bubble_cnt_o, m_bubble);
`endif
        end
        @(posedge clk);
        if (rst) begin
            m_issued = 0;
            m_bubble = 0;
        end else begin
            if (e_deque && m_issued < 65535) m_issued++;
            if (!m_valid && m_bubble < 65535) m_bubble++;
            if (e_restart) fetch_pc = m_raddr;
            else if (e_deque) fetch_pc = fetch_pc + 8'd1;
        end
        if (rst) begin
            m_wait = HOLD + 1; m_raddr = 0; m_valid = 0; m_instr = 0; m_pc = 0;
        end else if (rdr) begin
            m_wait = HOLD + 1; m_raddr = rda; m_valid = 0;
        end else begin
            if (m_wait > 0) m_wait--;
            if (e_deque) begin
                m_valid = 1; m_instr = mem[fetch_pc - 8'd1]; m_pc = fetch_pc - 8'd1;
            end else if (m_valid && !stl) begin
                m_valid = 0;
            end
        end
        #1;
    endtask

    initial begin
        logic [11:0] held;
        for (int i = 0; i < 256; i++) mem[i] = 12'($urandom);
        mem[8'h10] = 12'hE3F;
        mem[8'h11] = 12'h21A;
        fetch_pc = 0; m_wait = 0; m_valid = 0; m_instr = 0; m_pc = 0; m_raddr = 0;
        m_issued = 0; m_bubble = 0;
        reset_i = 1; instruction_ready_i = 0; instruction_data_i = 0; instruction_addr_i = 0;
        stall_i = 0; redirect_i = 0; redirect_addr_i = 0;
        @(posedge clk); #1;

        // Boot from reset with the FIFO already ready.
        cycle(1, 1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 1);
        check_eq("boot_restart", s_restart, 1);
        check_eq("boot_raddr", s_raddr, 0);
        check_eq("boot_deque", s_deque, 0);
        check_eq("boot_valid", s_valid, 0);
        check_eq("boot_fields", {s_opcode, s_ra, s_rb, s_imm, s_pc}, 0);
        for (int i = 0; i < 2; i++) begin
            cycle(0, 1, 0, 0, 0, 1);
            check_eq("boot_hold_deque", s_deque, 0);
        end
        cycle(0, 1, 0, 0, 0, 1);
        check_eq("boot_run_deque", s_deque, 1);

        // Redirect to 0x10, then stream four instructions.
        cycle(0, 0, 0, 1, 8'h10, 1);
        cycle(0, 1, 0, 0, 0, 1);
        check_eq("stream_raddr", s_raddr, 8'h10);
        for (int i = 0; i < 2; i++) cycle(0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            cycle(0, (i < 4), 0, 0, 0, 1);
            if (i < 4) check_eq("stream_deque", s_deque, 1);
            if (i > 0) begin
                check_eq("stream_valid", s_valid, 1);
                check_eq("stream_pc", s_pc, 8'h10 + i - 1);
            end
            if (i == 1) begin
                check_eq("dec_opcode", s_opcode, 3'b111);
                check_eq("dec_ra", s_ra, 3'b000);
                check_eq("dec_rb", s_rb, 3'b111);
                check_eq("dec_imm_neg", s_imm, 8'hFF);
            end
            if (i == 2) check_eq("dec_imm_pos", s_imm, 8'h1A);
        end

        // Stall holds the issue register; release issues the next one.
        held = mem[8'h14];
        cycle(0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 1, 0, 0, 1);
            check_eq("stall_deque", s_deque, 0);
            check_eq("stall_valid", s_valid, 1);
            check_eq("stall_pc", s_pc, 8'h14);
            check_eq("stall_opcode", s_opcode, held[11:9]);
        end
        cycle(0, 1, 0, 0, 0, 1);
        check_eq("release_deque", s_deque, 1);
        cycle(0, 1, 1, 0, 0, 1);
        check_eq("release_pc", s_pc, 8'h15);

        // Redirect during stall, then a second redirect during hold.
        cycle(0, 1, 1, 1, 8'h40, 1);
        check_eq("redir_deque", s_deque, 0);
        cycle(0, 1, 1, 0, 0, 1);
        check_eq("redir_valid", s_valid, 0);
        check_eq("redir_restart", s_restart, 1);
        check_eq("redir_raddr", s_raddr, 8'h40);
        cycle(0, 1, 0, 1, 8'h55, 1);
        check_eq("hold_redir_deque", s_deque, 0);
        cycle(0, 1, 0, 0, 0, 1);
        check_eq("re_restart", s_restart, 1);
        check_eq("re_raddr", s_raddr, 8'h55);

        // Reset mid-hold discards the pending target.
        cycle(0, 1, 0, 0, 0, 1);
        cycle(1, 1, 0, 0, 0, 1);
        cycle(0, 1, 0, 0, 0, 1);
        check_eq("rst_hold_restart", s_restart, 1);
        check_eq("rst_hold_raddr", s_raddr, 0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 8),
                  ($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0),
                  8'($urandom), 1);
        end

`ifdef DECODE_STATS_EN
        for (int i = 0; i < 70000; i++) cycle(0, 1, 0, 0, 0, 1);
        check_eq("issued_saturated", issued_cnt_o, 16'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
